// File: rtl/csa_pkg.sv
// Shared sizing and types for the 32-bit carry-select adder.
package csa_pkg;
    localparam int CSA_WIDTH      = 32;
    localparam int CSA_BLOCK_W    = 4;
    localparam int CSA_NUM_BLOCKS = CSA_WIDTH / CSA_BLOCK_W;

    typedef logic [CSA_WIDTH-1:0] csa_word_t;
endpackage

// File: rtl/csa_rca_block.sv
// BLOCK_W-bit ripple-carry adder built from full-adder equations.
module csa_rca_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] s,
    output logic               cout
);
    logic [BLOCK_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < BLOCK_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[BLOCK_W];
endmodule

// File: rtl/carry_select_adder_32b.sv
// Registered carry-select adder: {c_out, sum} = a + b + c_in, one-cycle latency.
// Define CSA_OVF_EN to add a registered signed-overflow flag (ovf).
module carry_select_adder_32b
    import csa_pkg::*;
#(
    parameter int WIDTH   = CSA_WIDTH,
    parameter int BLOCK_W = CSA_BLOCK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
`ifdef CSA_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int NB = WIDTH / BLOCK_W;

    logic [NB:0]        blk_c;
    logic [WIDTH-1:0]   sum_w;

    assign blk_c[0] = c_in;

    csa_rca_block #(.BLOCK_W(BLOCK_W)) u_blk0 (
        .a    (a[BLOCK_W-1:0]),
        .b    (b[BLOCK_W-1:0]),
        .cin  (blk_c[0]),
        .s    (sum_w[BLOCK_W-1:0]),
        .cout (blk_c[1])
    );

    // Upper blocks compute both carry-in cases; the incoming block carry picks one.
    for (genvar k = 1; k < NB; k++) begin : g_blk
        logic [BLOCK_W-1:0] s0, s1;
        logic               c0, c1;

        csa_rca_block #(.BLOCK_W(BLOCK_W)) u_rca0 (
            .a    (a[k*BLOCK_W +: BLOCK_W]),
            .b    (b[k*BLOCK_W +: BLOCK_W]),
            .cin  (1'b0),
            .s    (s0),
            .cout (c0)
        );

        csa_rca_block #(.BLOCK_W(BLOCK_W)) u_rca1 (
            .a    (a[k*BLOCK_W +: BLOCK_W]),
            .b    (b[k*BLOCK_W +: BLOCK_W]),
            .cin  (1'b1),
            .s    (s1),
            .cout (c1)
        );

        assign sum_w[k*BLOCK_W +: BLOCK_W] = blk_c[k] ? s1 : s0;
        assign blk_c[k+1]                  = blk_c[k] ? c1 : c0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
`ifdef CSA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_w;
                c_out <= blk_c[NB];
`ifdef CSA_OVF_EN
                ovf   <= (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_carry_select_adder_32b.sv
// Directed self-checking bench for carry_select_adder_32b.
module tb_carry_select_adder_32b;
    import csa_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      in_valid;
    csa_word_t a, b;
    logic      c_in;
    csa_word_t sum;
    logic      c_out;
    logic      out_valid;
`ifdef CSA_OVF_EN
    logic      ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    carry_select_adder_32b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
`ifdef CSA_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vv);
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = vv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'd5, 32'd0, 1'b0, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({c_out, sum, out_valid} !== 34'd0)
                $display("FAIL reset_hold[%0d]: got c_out=%0b sum=%h out_valid=%0b, want all 0", i, c_out, sum, out_valid);
            else pass_cnt++;
`ifdef CSA_OVF_EN
            total_cnt++;
            if (ovf !== 1'b0) $display("FAIL reset_ovf[%0d]: got %0b want 0", i, ovf);
            else pass_cnt++;
`endif
            step();
        end
        rst_n = 1'b1;
        total_cnt++;
        if (out_valid !== 1'b0 || sum !== 32'd0)
            $display("FAIL reset_release_pre: got sum=%h out_valid=%0b, want 0/0", sum, out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (sum !== 32'd5 || c_out !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL reset_first_result: got sum=%h c_out=%0b out_valid=%0b, want 5/0/1", sum, c_out, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] ta [6] = '{32'd12, 32'd2, 32'd22, 32'd233, 32'd602, 32'd2};
        logic [31:0] tb [6] = '{32'd8,  32'd8, 32'd178, 32'd108, 32'd231, 32'd8};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] te [6] = '{32'd20, 32'd10, 32'd200, 32'd342, 32'd833, 32'd11};
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b1);
            step();
            total_cnt++;
            if (sum !== te[i] || c_out !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL basic[%0d]: got sum=%0d c_out=%0b out_valid=%0b, want %0d/0/1", i, sum, c_out, out_valid, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_carry_chain();
        drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (sum !== 32'h0 || c_out !== 1'b1)
            $display("FAIL chain_ones_plus_1: got c_out=%0b sum=%h, want 1/00000000", c_out, sum);
        else pass_cnt++;
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (sum !== 32'hFFFF_FFFF || c_out !== 1'b1)
            $display("FAIL chain_ones_ones_1: got c_out=%0b sum=%h, want 1/ffffffff", c_out, sum);
        else pass_cnt++;
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        step();
        total_cnt++;
        if (sum !== 32'h0 || c_out !== 1'b0)
            $display("FAIL zero_sum: got c_out=%0b sum=%h, want 0/00000000", c_out, sum);
        else pass_cnt++;
    endtask

    task automatic test_block_boundary();
        logic [31:0] ta [7] = '{32'h0000_000F, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_FFFF,
                                32'h000F_FFFF, 32'h00FF_FFFF, 32'h0FFF_FFFF};
        logic [31:0] te [7] = '{32'h0000_0010, 32'h0000_0100, 32'h0000_1000, 32'h0001_0000,
                                32'h0010_0000, 32'h0100_0000, 32'h1000_0000};
        for (int i = 0; i < 7; i++) begin
            drive(ta[i], 32'h1, 1'b0, 1'b1);
            step();
            total_cnt++;
            if (sum !== te[i] || c_out !== 1'b0)
                $display("FAIL boundary[%0d]: got c_out=%0b sum=%h, want 0/%h", i, c_out, sum, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        drive(32'd1000, 32'd234, 1'b0, 1'b1);
        step();
        drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (sum !== 32'd1234 || c_out !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL hold[%0d]: got sum=%0d c_out=%0b out_valid=%0b, want 1234/0/0", i, sum, c_out, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        drive(32'd100, 32'd200, 1'b0, 1'b1);
        step();
        total_cnt++;
        if (sum !== 32'd300 || out_valid !== 1'b1)
            $display("FAIL mid_pre: got sum=%0d out_valid=%0b, want 300/1", sum, out_valid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (sum !== 32'd0 || c_out !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL mid_async_clear: got sum=%0d c_out=%0b out_valid=%0b, want 0/0/0", sum, c_out, out_valid);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        drive(32'd7, 32'd9, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (sum !== 32'd17 || out_valid !== 1'b1)
            $display("FAIL mid_recover: got sum=%0d out_valid=%0b, want 17/1", sum, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] exp;
        int          errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rc  = 1'($urandom_range(1, 0));
            exp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            drive(ra, rb, rc, 1'b1);
            step();
            total_cnt++;
            if ({c_out, sum} !== exp) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: %h+%h+%0b got %h want %h", i, ra, rb, rc, {c_out, sum}, exp);
                errs++;
            end else pass_cnt++;
`ifdef CSA_OVF_EN
            total_cnt++;
            if (ovf !== ((ra[31] == rb[31]) && (exp[31] != ra[31]))) begin
                if (errs < 10) $display("FAIL random_ovf[%0d]: got %0b", i, ovf);
                errs++;
            end else pass_cnt++;
`endif
        end
`ifdef CSA_OVF_EN
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        step();
        total_cnt++;
        if (ovf !== 1'b1 || sum !== 32'h8000_0000)
            $display("FAIL ovf_max_pos: got ovf=%0b sum=%h, want 1/80000000", ovf, sum);
        else pass_cnt++;
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_basic();
        test_carry_chain();
        test_block_boundary();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/carry_select_adder_32b.md
Name: carry_select_adder_32b

Overview:
- 32-bit carry-select adder computing sum = a + b + c_in, with carry-out.
- Datapath is split into fixed-width blocks. Each block above the lowest precomputes results for carry-in 0 and carry-in 1, and the real block carry selects between them.
- Result is registered once at the output, on the single core clock.
- Used as a generic fast adder inside arithmetic datapaths.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK_W.
- BLOCK_W, 4, bits per carry-select block; WIDTH/BLOCK_W blocks in total.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  qualifies a, b, c_in this cycle.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- c_in  input  1  carry-in into bit 0.
- sum  output  WIDTH  registered (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset: while rst_n = 0, sum = 0, c_out = 0, out_valid = 0, applied immediately (asynchronous). Release is synchronous-safe: the first capture happens at the first rising edge with rst_n = 1.
- Latency: exactly 1 cycle. Operands presented at edge N appear on sum/c_out/out_valid after edge N+1. Throughput is one operation per cycle, with no stall and no backpressure.
- Capture rule:
  - When in_valid = 1, sum/c_out load the new result.
  - When in_valid = 0, sum/c_out hold their previous value.
  - out_valid follows in_valid every cycle.
- Block 0 structure: a plain ripple-carry adder of BLOCK_W bits, with carry-in c_in.
- Block k > 0 structure:
  - Two BLOCK_W-bit ripple adders, one with carry-in 0 and one with carry-in 1.
  - Each produces a partial sum and a block carry.
  - The carry out of block k-1 selects both the sum slice and the outgoing carry of block k.
- c_out is the selected carry of the top block.
- Arithmetic rules:
  - Unsigned modulo 2^WIDTH; {c_out, sum} equals a + b + c_in exactly over WIDTH+1 bits.
  - No saturation.
  - The combinational path must be purely structural and must match a behavioural "+" bit-for-bit for all inputs.
- Boundary cases:
  - all-ones + 0 + 1 → sum = 0, c_out = 1.
  - all-ones + all-ones + 1 → sum = all-ones, c_out = 1.
  - 0 + 0 + 0 → sum = 0, c_out = 0.
- Reset mid-stream: asserting rst_n while out_valid = 1 clears all outputs immediately, and the in-flight result is discarded.
- X-free: no output may go X after reset when the inputs are known.

Optional Feature:
- Macro CSA_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), registered alongside sum with the same capture rule.
  - ovf = 1 when signed two's-complement overflow occurs, i.e. a[MSB] == b[MSB] and sum[MSB] != a[MSB].
  - ovf resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package csa_pkg:
  - localparams CSA_WIDTH = 32 and CSA_BLOCK_W = 4.
  - Derived CSA_NUM_BLOCKS = CSA_WIDTH / CSA_BLOCK_W.
  - Typedef csa_word_t (logic [CSA_WIDTH-1:0]).
- Sub-module csa_rca_block:
  - Parameterised BLOCK_W ripple adder built from full-adder equations, with inputs a, b, cin and outputs s, cout.
  - Top level instantiates it once for block 0 and twice per upper block (cin tied 0 and 1), plus the per-block 2:1 select muxes.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 and a = 5 → sum = 0, c_out = 0, out_valid = 0 throughout. After release, first result appears one edge later.
- Basic sequence, one per cycle with in_valid = 1: 12+8+0 → 20; 2+8+0 → 10; 22+178+0 → 200; 233+108+1 → 342; 602+231+0 → 833; 2+8+1 → 11. Each appears one cycle later, c_out = 0, out_valid = 1.
- Carry chain: a = 0xFFFFFFFF, b = 0, c_in = 1 → sum = 0, c_out = 1. Then a = b = 0xFFFFFFFF, c_in = 1 → sum = 0xFFFFFFFF, c_out = 1.
- Block-boundary carry: a = 0x0000000F, b = 0x00000001, c_in = 0 → sum = 0x00000010. Repeat for each nibble boundary up to 0x0FFFFFFF + 1 → 0x10000000.
- Hold and reset: in_valid = 0 with new operands → sum unchanged, out_valid = 0. Assert rst_n = 0 mid-stream → outputs clear without waiting for a clock edge.
- Random: 10k random a, b, c_in compared against a behavioural 33-bit sum; with CSA_OVF_EN, 0x7FFFFFFF + 1 → ovf = 1.
